// File: rtl/shift_sequencer.sv
// Multi-cycle logical left shifter: shifts a captured byte one position per clock,
// reporting result, last carry-out and zero status with a start/busy/done handshake.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] shift_amt,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] amt_sat;

  // Handshake: start is taken on a rising edge only while not busy (IDLE or DONE);
  // done pulses for one cycle once result/carry are final, and busy never overlaps done.
  assign amt_sat = (shift_amt > WIDTH_C) ? WIDTH_C : shift_amt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          result_d = data_in;
          carry_d  = 1'b0;
          cnt_d    = amt_sat;
          state_d  = (amt_sat == '0) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = {result_q[WIDTH-2:0], 1'b0};
        carry_d  = result_q[WIDTH-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = (result_q == '0);
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer: a driver pushes the expected
// outcome of every accepted operation, a monitor pops and compares on each done.
module tb_shift_sequencer;
  localparam int W = 18;  // {busy_cycles[7:0], result[7:0], carry, zero}

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] shift_amt;
  logic [7:0] result;
  logic       carry_flag;
  logic       zero_flag;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .shift_amt(shift_amt), .result(result), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: an N-place logical left shift of a byte, viewed as a 16-bit product.
  function automatic logic [W-1:0] model(input logic [7:0] d, input logic [3:0] a);
    int n;
    logic [15:0] w;
    logic [7:0] n8;
    n  = (a > 4'd8) ? 8 : int'(a);
    w  = {8'h00, d} << n;
    n8 = 8'(n);
    return {n8, w[7:0], (n == 0) ? 1'b0 : w[8], (w[7:0] == 8'h00)};
  endfunction

  // driver tasks
  task automatic issue(input logic [7:0] d, input logic [3:0] a);
    data_in   = d;
    shift_amt = a;
    start     = 1'b1;
    exp_q.push_back(model(d, a));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic idle_gap(input int n);
    repeat (n + 1) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, int'(state_dbg), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_carry"}, int'(carry_flag), 0);
    check({tag, "_zero"}, int'(zero_flag), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      busy_cnt = 0;
    end else if (done) begin
      check("busy_with_done", int'(busy), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", int'(result), int'(e[9:2]));
        check("carry", int'(carry_flag), int'(e[1]));
        check("zero", int'(zero_flag), int'(e[0]));
        check("busy_cycles", busy_cnt, int'(e[17:10]));
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; data_in = '0; shift_amt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    issue(8'h01, 4'd1);  wait_done(); idle_gap(1);
    issue(8'h95, 4'd1);  wait_done(); idle_gap(0);
    issue(8'h95, 4'd3);  wait_done(); idle_gap(2);
    issue(8'hFF, 4'd8);  wait_done(); idle_gap(1);
    issue(8'hFF, 4'd12); wait_done(); idle_gap(1);
    issue(8'h80, 4'd0);  wait_done(); idle_gap(1);

    // start pulses while shifting must be ignored
    issue(8'h95, 4'd5);
    @(posedge clk); #1;
    data_in = 8'h00; shift_amt = 4'd0; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done();

    // new operation accepted in the done cycle
    issue(8'h01, 4'd2); wait_done(); idle_gap(1);

    // reset at E2 of a 5-place shift aborts with no done afterwards
    issue(8'h5A, 4'd5);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    check_reset_state("abort");
    idle_gap(10);

    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 4'($urandom_range(0, 15)));
      wait_done();
      if ($urandom_range(0, 2) != 0) idle_gap($urandom_range(0, 3));
    end
    idle_gap(1);

    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin @(posedge clk); #1; k++; end
      check("pending_at_end", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
